// File: rtl/sr_btn_debounce_if.sv
// Pin bundle between the pushbutton front end and its user: raw buttons in,
// clean latch pulses, debounced levels and the conflict strobe out.
interface sr_btn_debounce_if;
    logic set_btn;
    logic reset_btn;
    logic Sbar;
    logic Rbar;
    logic set_db;
    logic reset_db;
    logic conflict;

    modport master (
        output set_btn,
        output reset_btn,
        input  Sbar,
        input  Rbar,
        input  set_db,
        input  reset_db,
        input  conflict
    );

    modport slave (
        input  set_btn,
        input  reset_btn,
        output Sbar,
        output Rbar,
        output set_db,
        output reset_db,
        output conflict
    );
endinterface

// File: rtl/sr_btn_debounce.sv
// Debounced two-button front end for a NAND SR latch: each accepted press becomes a
// PULSE_CYCLES-long active-low pulse, and Sbar/Rbar are never low together.
module sr_btn_debounce #(
    parameter int DB_CYCLES    = 16,
    parameter int PULSE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rstbar,
    sr_btn_debounce_if.slave    bus
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DB_CYCLES - 1);
    localparam logic [PW-1:0] PCNT_LOAD = PW'(PULSE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b001,
        ST_PULSE_S = 3'b010,
        ST_PULSE_R = 3'b100
    } state_t;

    // Channel 0 is set, channel 1 is reset.
    logic [1:0] btn_raw;
    logic [1:0] db;
    logic [1:0] req;

    assign btn_raw = {bus.reset_btn, bus.set_btn};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic          sync1_q;
            logic          sync2_q;
            logic          db_q;
            logic          db_d;
            logic          db_prev_q;
            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;

            // Any cycle where the synchronised level equals db restarts the count.
            always_comb begin
                db_d  = db_q;
                cnt_d = '0;
                if (sync2_q != db_q) begin
                    if (cnt_q == CNT_LAST) begin
                        db_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            always_ff @(posedge clk or negedge rstbar) begin
                if (!rstbar) begin
                    sync1_q   <= 1'b0;
                    sync2_q   <= 1'b0;
                    db_q      <= 1'b0;
                    db_prev_q <= 1'b0;
                    cnt_q     <= '0;
                end else begin
                    sync1_q   <= btn_raw[gi];
                    sync2_q   <= sync1_q;
                    db_q      <= db_d;
                    db_prev_q <= db_q;
                    cnt_q     <= cnt_d;
                end
            end

            assign db[gi]  = db_q;
            assign req[gi] = db_q & ~db_prev_q;
        end
    endgenerate

    state_t        state_q;
    state_t        state_d;
    logic [PW-1:0] pcnt_q;
    logic [PW-1:0] pcnt_d;
    logic          pend_s_q;
    logic          pend_s_d;
    logic          pend_r_q;
    logic          pend_r_d;
    logic          conflict_q;
    logic          conflict_d;
    logic          sbar_q;
    logic          sbar_d;
    logic          rbar_q;
    logic          rbar_d;
    logic          want_s;
    logic          want_r;
    logic          choose;

    // A request for the channel already pulsing is not folded into its want_* term,
    // which is what drops it; the other channel's request is remembered as pending.
    always_comb begin
        state_d    = state_q;
        pcnt_d     = pcnt_q;
        pend_s_d   = pend_s_q;
        pend_r_d   = pend_r_q;
        conflict_d = 1'b0;
        want_s     = 1'b0;
        want_r     = 1'b0;
        choose     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                want_s = req[0] | pend_s_q;
                want_r = req[1] | pend_r_q;
                choose = 1'b1;
            end
            ST_PULSE_S: begin
                want_s = pend_s_q;
                want_r = req[1] | pend_r_q;
                choose = (pcnt_q == '0);
            end
            ST_PULSE_R: begin
                want_s = req[0] | pend_s_q;
                want_r = pend_r_q;
                choose = (pcnt_q == '0);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (choose) begin
            pend_s_d = 1'b0;
            pend_r_d = 1'b0;
            if (want_r) begin
                state_d    = ST_PULSE_R;
                pcnt_d     = PCNT_LOAD;
                conflict_d = want_s;
            end else if (want_s) begin
                state_d = ST_PULSE_S;
                pcnt_d  = PCNT_LOAD;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            pend_s_d = want_s;
            pend_r_d = want_r;
            if (state_q != ST_IDLE) begin
                pcnt_d = pcnt_q - PW'(1);
            end
        end

        sbar_d = (state_d != ST_PULSE_S);
        rbar_d = (state_d != ST_PULSE_R);
    end

    always_ff @(posedge clk or negedge rstbar) begin
        if (!rstbar) begin
            state_q    <= ST_IDLE;
            pcnt_q     <= '0;
            pend_s_q   <= 1'b0;
            pend_r_q   <= 1'b0;
            conflict_q <= 1'b0;
            sbar_q     <= 1'b1;
            rbar_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            pend_s_q   <= pend_s_d;
            pend_r_q   <= pend_r_d;
            conflict_q <= conflict_d;
            sbar_q     <= sbar_d;
            rbar_q     <= rbar_d;
        end
    end

    assign bus.Sbar     = sbar_q;
    assign bus.Rbar     = rbar_q;
    assign bus.set_db   = db[0];
    assign bus.reset_db = db[1];
    assign bus.conflict = conflict_q;

endmodule

// File: tb/tb_sr_btn_debounce.sv
// Directed bench for sr_btn_debounce: expected output changes (edge number + value)
// are queued by the stimulus and checked by an independent monitor.
module tb_sr_btn_debounce;

    typedef struct {
        int         edge_no;
        logic [4:0] val;     // {conflict, reset_db, set_db, Rbar, Sbar}
    } exp_t;

    logic clk = 1'b0;
    logic rstbar = 1'b1;
    int   edge_n = 0;
    int   nvec = 0;
    int   nfail = 0;
    bit   mon_on = 1'b0;
    exp_t exp_q[$];
    logic [4:0] mon_prev;
    logic [4:0] mon_cur;
    exp_t       mon_e;

    sr_btn_debounce_if bus ();

    sr_btn_debounce #(.DB_CYCLES(16), .PULSE_CYCLES(2)) dut (
        .clk    (clk),
        .rstbar (rstbar),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic void push(int e, logic [4:0] v);
        exp_t x;
        x.edge_no = e;
        x.val     = v;
        exp_q.push_back(x);
    endfunction

    task automatic wait_to(int e);
        while (edge_n < e) @(negedge clk);
    endtask

    task automatic check_bit(string name, logic act, logic req);
        nvec++;
        $display("check %s act=%b req=%b", name, act, req);
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %b, expected %b", name, act, req);
        end
    endtask

    task automatic check_drained(string name);
        nvec++;
        $display("drain %s outstanding=%0d", name, exp_q.size());
        if (exp_q.size() != 0) begin
            nfail++;
            $display("FAIL %s: %0d expected events never seen, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: any change of the output vector is a DUT response to score.
    always @(negedge clk) begin
        if (mon_on) begin
            mon_cur = {bus.conflict, bus.reset_db, bus.set_db, bus.Rbar, bus.Sbar};
            if ((mon_cur[0] | mon_cur[1]) !== 1'b1) begin
                nfail++;
                $display("FAIL invariant edge %0d: Sbar=%b Rbar=%b, expected not both 0",
                         edge_n, mon_cur[0], mon_cur[1]);
            end
            if (mon_cur !== mon_prev) begin
                nvec++;
                if (exp_q.size() == 0) begin
                    nfail++;
                    $display("FAIL unexpected edge %0d: outputs %b, expected no change from %b",
                             edge_n, mon_cur, mon_prev);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("event edge %0d outs=%b (expected edge %0d outs=%b)",
                             edge_n, mon_cur, mon_e.edge_no, mon_e.val);
                    if (mon_e.edge_no != edge_n || mon_e.val !== mon_cur) begin
                        nfail++;
                        $display("FAIL event: got edge %0d outs %b, expected edge %0d outs %b",
                                 edge_n, mon_cur, mon_e.edge_no, mon_e.val);
                    end
                end
                mon_prev = mon_cur;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int e;
        int r;
        bus.set_btn   = 1'b0;
        bus.reset_btn = 1'b0;
        #1 rstbar = 1'b0;
        #1;
        check_bit("rst_Sbar",     bus.Sbar,     1'b1);
        check_bit("rst_Rbar",     bus.Rbar,     1'b1);
        check_bit("rst_set_db",   bus.set_db,   1'b0);
        check_bit("rst_reset_db", bus.reset_db, 1'b0);
        check_bit("rst_conflict", bus.conflict, 1'b0);
        wait_to(3);
        rstbar   = 1'b1;
        mon_prev = 5'b00011;
        mon_on   = 1'b1;
        wait_to(6);

        // 1 + 6: single set press, then release produces no pulse
        e = edge_n;
        bus.set_btn = 1'b1;
        push(e + 18, 5'b00111);
        push(e + 19, 5'b00110);
        push(e + 21, 5'b00111);
        wait_to(e + 40);
        bus.set_btn = 1'b0;
        push(e + 58, 5'b00011);
        wait_to(e + 70);
        check_drained("t1_set_press");

        // 2: bouncing set never settles long enough
        e = edge_n;
        for (int i = 0; i < 10; i++) begin
            bus.set_btn = ~bus.set_btn;
            wait_to(e + 5 * (i + 1));
        end
        bus.set_btn = 1'b0;
        wait_to(e + 80);
        check_drained("t2_bounce");

        // 3: simultaneous presses, reset wins with a conflict strobe
        e = edge_n;
        bus.set_btn   = 1'b1;
        bus.reset_btn = 1'b1;
        push(e + 18, 5'b01111);
        push(e + 19, 5'b11101);
        push(e + 20, 5'b01101);
        push(e + 21, 5'b01111);
        wait_to(e + 30);
        bus.set_btn   = 1'b0;
        bus.reset_btn = 1'b0;
        push(e + 48, 5'b00011);
        wait_to(e + 60);
        check_drained("t3_simultaneous");

        // 4: reset then set one cycle later, back-to-back pulses
        e = edge_n;
        bus.reset_btn = 1'b1;
        wait_to(e + 1);
        bus.set_btn = 1'b1;
        push(e + 18, 5'b01011);
        push(e + 19, 5'b01101);
        push(e + 21, 5'b01110);
        push(e + 23, 5'b01111);
        wait_to(e + 31);
        bus.set_btn   = 1'b0;
        bus.reset_btn = 1'b0;
        push(e + 49, 5'b00011);
        wait_to(e + 60);
        check_drained("t4_back_to_back");

        // 5: reset mid-pulse with the button still held
        e = edge_n;
        bus.set_btn = 1'b1;
        push(e + 18, 5'b00111);
        push(e + 19, 5'b00110);
        wait_to(e + 19);
        check_bit("t5_pulse_low", bus.Sbar, 1'b0);
        push(e + 20, 5'b00011);
        #2 rstbar = 1'b0;
        #1;
        check_bit("t5_async_Sbar",   bus.Sbar,   1'b1);
        check_bit("t5_async_set_db", bus.set_db, 1'b0);
        wait_to(e + 22);
        rstbar = 1'b1;
        r = edge_n;
        push(r + 18, 5'b00111);
        push(r + 19, 5'b00110);
        push(r + 21, 5'b00111);
        wait_to(r + 30);
        bus.set_btn = 1'b0;
        push(r + 48, 5'b00011);
        wait_to(r + 60);
        check_drained("t5_reset_mid_pulse");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
